// File: rtl/fp_rf_pkg.sv
// Shared defaults and types for the multi-ported FP register file.
// Optional same-cycle write-to-read bypass: FP_RF_BYPASS_EN.
package fp_rf_pkg;

    localparam int FP_XLEN  = 32;
    localparam int FP_NREGS = 32;
    localparam int FP_NRD   = 3;
    localparam int FP_NWR   = 2;
    localparam int FP_AW    = $clog2(FP_NREGS);

    typedef logic [FP_AW-1:0] fp_rf_addr_t;

endpackage

// File: rtl/fp_rf_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback or flush.
// Read-side busy comes from registered state only.
module fp_rf_scoreboard
    import fp_rf_pkg::*;
#(
    parameter int NREGS = FP_NREGS,
    parameter int NRD   = FP_NRD,
    parameter int NWR   = FP_NWR
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NRD-1:0][$clog2(NREGS)-1:0]   frs_addr,
    output logic [NRD-1:0]                      frs_busy,
    input  logic [NWR-1:0]                      frd_en,
    input  logic [NWR-1:0][$clog2(NREGS)-1:0]   frd_addr,
    input  logic                                sb_set_en,
    input  logic [$clog2(NREGS)-1:0]            sb_set_addr,
    input  logic                                flush
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Order matters: writeback clear, then issue set, then flush wipes all.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NWR; w++) begin
            if (frd_en[w]) busy_d[frd_addr[w]] = 1'b0;
        end
        if (sb_set_en) busy_d[sb_set_addr] = 1'b1;
        if (flush) busy_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    always_comb begin
        frs_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            frs_busy[p] = busy_q[frs_addr[p]];
        end
    end

endmodule

// File: rtl/fp_regfile_mp.sv
// Multi-ported FP register file with issue scoreboard.
// Define FP_RF_BYPASS_EN to forward same-cycle writes to the read ports.
module fp_regfile_mp
    import fp_rf_pkg::*;
#(
    parameter int XLEN  = FP_XLEN,
    parameter int NREGS = FP_NREGS,
    parameter int NRD   = FP_NRD,
    parameter int NWR   = FP_NWR
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NRD-1:0][$clog2(NREGS)-1:0]   frs_addr,
    output logic [NRD-1:0][XLEN-1:0]            frs_data,
    output logic [NRD-1:0]                      frs_busy,
    input  logic [NWR-1:0]                      frd_en,
    input  logic [NWR-1:0][$clog2(NREGS)-1:0]   frd_addr,
    input  logic [NWR-1:0][XLEN-1:0]            frd_data,
    input  logic                                sb_set_en,
    input  logic [$clog2(NREGS)-1:0]            sb_set_addr,
    input  logic                                flush
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [NRD-1:0]  sb_busy;

    // Later ports overwrite earlier ones, so the highest index wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (frd_en[w]) regs_q[frd_addr[w]] <= frd_data[w];
            end
        end
    end

    fp_rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .frs_addr    (frs_addr),
        .frs_busy    (sb_busy),
        .frd_en      (frd_en),
        .frd_addr    (frd_addr),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .flush       (flush)
    );

`ifdef FP_RF_BYPASS_EN
    logic [NRD-1:0] hit;

    always_comb begin
        frs_data = '0;
        frs_busy = '0;
        hit      = '0;
        for (int p = 0; p < NRD; p++) begin
            frs_data[p] = regs_q[frs_addr[p]];
            for (int w = 0; w < NWR; w++) begin
                if (frd_en[w] && frd_addr[w] == frs_addr[p]) begin
                    frs_data[p] = frd_data[w];
                    hit[p]      = 1'b1;
                end
            end
            // A completing writeback reads as free unless reissued now.
            if (hit[p] && !(sb_set_en && sb_set_addr == frs_addr[p]))
                frs_busy[p] = 1'b0;
            else
                frs_busy[p] = sb_busy[p];
        end
    end
`else
    always_comb begin
        frs_data = '0;
        for (int p = 0; p < NRD; p++) begin
            frs_data[p] = regs_q[frs_addr[p]];
        end
        frs_busy = sb_busy;
    end
`endif

endmodule

// File: tb/tb_fp_regfile_mp.sv
// Scoreboard-driven bench for fp_regfile_mp (default and small configs).
// Expected reads are queued at stimulus time and compared once settled.
module tb_fp_regfile_mp;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic [2:0][4:0]  frs_addr;
    logic [2:0][31:0] frs_data;
    logic [2:0]       frs_busy;
    logic [1:0]       frd_en;
    logic [1:0][4:0]  frd_addr;
    logic [1:0][31:0] frd_data;
    logic             sb_set_en;
    logic [4:0]       sb_set_addr;
    logic             flush;

    logic [1:0][3:0]  s_rs_addr;
    logic [1:0][31:0] s_rs_data;
    logic [1:0]       s_rs_busy;
    logic [0:0]       s_rd_en;
    logic [0:0][3:0]  s_rd_addr;
    logic [0:0][31:0] s_rd_data;
    logic             s_set_en;
    logic [3:0]       s_set_addr;
    logic             s_flush;

    fp_regfile_mp dut (
        .clk         (clk),
        .rst         (rst),
        .frs_addr    (frs_addr),
        .frs_data    (frs_data),
        .frs_busy    (frs_busy),
        .frd_en      (frd_en),
        .frd_addr    (frd_addr),
        .frd_data    (frd_data),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .flush       (flush)
    );

    fp_regfile_mp #(
        .XLEN  (32),
        .NREGS (16),
        .NRD   (2),
        .NWR   (1)
    ) dut_small (
        .clk         (clk),
        .rst         (rst),
        .frs_addr    (s_rs_addr),
        .frs_data    (s_rs_data),
        .frs_busy    (s_rs_busy),
        .frd_en      (s_rd_en),
        .frd_addr    (s_rd_addr),
        .frd_data    (s_rd_data),
        .sb_set_en   (s_set_en),
        .sb_set_addr (s_set_addr),
        .flush       (s_flush)
    );

    typedef struct {
        int          inst;
        int          port;
        logic [31:0] data;
        logic        busy;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_pass = 0;

`ifdef FP_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        frd_en    = '0;
        sb_set_en = 1'b0;
        flush     = 1'b0;
        s_rd_en   = '0;
        s_set_en  = 1'b0;
        s_flush   = 1'b0;
    endtask

    task automatic wr(input int w, input logic [4:0] a,
                      input logic [31:0] d);
        frd_en[w]   = 1'b1;
        frd_addr[w] = a;
        frd_data[w] = d;
    endtask

    task automatic set(input logic [4:0] a);
        sb_set_en   = 1'b1;
        sb_set_addr = a;
    endtask

    task automatic rd(input int p, input logic [4:0] a,
                      input logic [31:0] d, input logic b,
                      input string tag);
        exp_t e;
        frs_addr[p] = a;
        e.inst = 0;
        e.port = p;
        e.data = d;
        e.busy = b;
        e.tag  = tag;
        sbq.push_back(e);
    endtask

    task automatic rd_s(input int p, input logic [3:0] a,
                        input logic [31:0] d, input logic b,
                        input string tag);
        exp_t e;
        s_rs_addr[p] = a;
        e.inst = 1;
        e.port = p;
        e.data = d;
        e.busy = b;
        e.tag  = tag;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] gd;
        logic        gb;
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.inst == 0) begin
                gd = frs_data[e.port];
                gb = frs_busy[e.port];
            end else begin
                gd = s_rs_data[e.port];
                gb = s_rs_busy[e.port];
            end
            check(e.tag, gd, e.data);
            check({e.tag, "_busy"}, {31'd0, gb}, {31'd0, e.busy});
        end
    endtask

    initial begin
        rst = 1'b1;
        frs_addr = '0; frd_addr = '0; frd_data = '0;
        sb_set_addr = '0;
        s_rs_addr = '0; s_rd_addr = '0; s_rd_data = '0;
        s_set_addr = '0;
        idle();
        cyc(); cyc();
        rst = 1'b0;

        rd(0, 5'd0,  32'h0, 1'b0, "rst_f0");
        rd(1, 5'd17, 32'h0, 1'b0, "rst_f17");
        rd(2, 5'd31, 32'h0, 1'b0, "rst_f31");
        drain();

        // reset clears data and busy; same-cycle write/set are dropped
        wr(0, 5'd5, 32'h3F800000);
        cyc(); idle();
        rd(0, 5'd5, 32'h3F800000, 1'b0, "wr_f5");
        drain();
        set(5'd5); cyc(); idle();
        rd(0, 5'd5, 32'h3F800000, 1'b1, "busy_f5");
        drain();
        rst = 1'b1;
        wr(1, 5'd6, 32'hCAFEF00D);
        set(5'd6);
        cyc(); idle(); rst = 1'b0;
        rd(0, 5'd5, 32'h0, 1'b0, "post_rst_f5");
        rd(1, 5'd6, 32'h0, 1'b0, "post_rst_f6");
        drain();

        // dual write conflict: highest port wins
        wr(0, 5'd7, 32'h11111111);
        wr(1, 5'd7, 32'h22222222);
        cyc(); idle();
        rd(0, 5'd7, 32'h22222222, 1'b0, "dual_f7");
        drain();
        wr(0, 5'd8, 32'hAAAA0001);
        wr(1, 5'd10, 32'hBBBB0002);
        cyc(); idle();
        rd(0, 5'd8,  32'hAAAA0001, 1'b0, "dual_f8");
        rd(1, 5'd10, 32'hBBBB0002, 1'b0, "dual_f10");
        rd(2, 5'd7,  32'h22222222, 1'b0, "dual_f7b");
        drain();

        // scoreboard: set not visible same cycle, then busy 4 cycles
        set(5'd3);
        rd(2, 5'd3, 32'h0, 1'b0, "set_same");
        drain();
        cyc(); idle();
        for (int i = 0; i < 4; i++) begin
            rd(2, 5'd3, 32'h0, 1'b1, $sformatf("busy_c%0d", i));
            drain();
            cyc();
        end
        wr(1, 5'd3, 32'h40490FDB);
        rd(2, 5'd3, BYP ? 32'h40490FDB : 32'h0, BYP ? 1'b0 : 1'b1,
           "wb_same");
        drain();
        cyc(); idle();
        rd(2, 5'd3, 32'h40490FDB, 1'b0, "wb_done");
        drain();
        set(5'd3);
        wr(0, 5'd3, 32'h12121212);
        cyc(); idle();
        rd(2, 5'd3, 32'h12121212, 1'b1, "set_over_clr");
        drain();

        // flush clears every busy bit, including a same-cycle set
        set(5'd1);  cyc();
        set(5'd2);  cyc();
        set(5'd31); cyc(); idle();
        rd(0, 5'd1,  32'h0, 1'b1, "pre_fl_f1");
        rd(1, 5'd2,  32'h0, 1'b1, "pre_fl_f2");
        rd(2, 5'd31, 32'h0, 1'b1, "pre_fl_f31");
        drain();
        flush = 1'b1;
        set(5'd4);
        cyc(); idle();
        rd(0, 5'd1,  32'h0, 1'b0, "fl_f1");
        rd(1, 5'd2,  32'h0, 1'b0, "fl_f2");
        rd(2, 5'd31, 32'h0, 1'b0, "fl_f31");
        drain();
        rd(0, 5'd3, 32'h12121212, 1'b0, "fl_f3");
        rd(1, 5'd4, 32'h0,        1'b0, "fl_f4");
        rd(2, 5'd7, 32'h22222222, 1'b0, "fl_f7");
        drain();

        // same-cycle read of a write: bypassed or old value
        wr(0, 5'd9, 32'h12345678);
        cyc(); idle();
        wr(1, 5'd9, 32'hDEADBEEF);
        rd(0, 5'd9, BYP ? 32'hDEADBEEF : 32'h12345678, 1'b0, "byp_f9");
        rd(1, 5'd8, 32'hAAAA0001, 1'b0, "byp_f8");
        drain();
        cyc(); idle();
        rd(0, 5'd9, 32'hDEADBEEF, 1'b0, "after_f9");
        drain();

        // reduced configuration round-trip
        rd_s(1, 4'd15, 32'h0, 1'b0, "s_rst_f15");
        drain();
        s_rd_en = 1'b1; s_rd_addr[0] = 4'd15; s_rd_data[0] = 32'hA5A5C3C3;
        s_set_en = 1'b1; s_set_addr = 4'd14;
        cyc(); idle();
        rd_s(1, 4'd15, 32'hA5A5C3C3, 1'b0, "s_f15");
        rd_s(0, 4'd14, 32'h0,        1'b1, "s_f14");
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fp_regfile_mp.md
FP_REGFILE_MP -- requirements
Module: fp_regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of each FP register.
REQ-002 SHALL have parameter NREGS, default 32, register count; power of two, at least 2; AW = $clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 3, number of read ports (frs1/frs2/frs3 for FMA).
REQ-004 SHALL have parameter NWR, default 2, number of write ports.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port frs_addr  input  NRD x AW  read address per read port.
REQ-008 SHALL have port frs_data  output  NRD x XLEN  read data per read port.
REQ-009 SHALL have port frs_busy  output  NRD  scoreboard busy bit of each read address.
REQ-010 SHALL have port frd_en  input  NWR  write enable per write port.
REQ-011 SHALL have port frd_addr  input  NWR x AW  write address per write port.
REQ-012 SHALL have port frd_data  input  NWR x XLEN  write data per write port.
REQ-013 SHALL have port sb_set_en  input  1  issue of an FP op that targets sb_set_addr.
REQ-014 SHALL have port sb_set_addr  input  AW  destination register of the issued op.
REQ-015 SHALL have port flush  input  1  pipeline flush; clears all busy bits.

Function
REQ-016 SHALL read combinationally: frs_data[p] = register[frs_addr[p]], with no latency.
REQ-017 SHALL update register[frd_addr[w]] <= frd_data[w] at the clock edge for each w with frd_en[w]=1.
REQ-018 SHALL, when several enabled write ports share one address, give priority to the highest port index.
REQ-019 SHALL keep a busy bit per register; busy SHALL be set at the edge when sb_set_en=1 for sb_set_addr.
REQ-020 SHALL clear busy[frd_addr[w]] at the edge when frd_en[w]=1 (writeback completes the op).
REQ-021 SHALL apply set over clear when a set and a writeback target the same register in one cycle; the register ends busy.
REQ-022 SHALL clear all busy bits on flush=1 at the edge, including a same-cycle set; register data SHALL NOT change.
REQ-023 SHALL drive frs_busy[p] = busy[frs_addr[p]] from registered state only, so same-cycle set or clear is not visible.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, zero all registers and all busy bits; rst SHALL override flush, writes and sets.
REQ-025 SHALL output frs_data = 0 and frs_busy = 0 in the cycle after reset for any address.
REQ-026 SHALL discard any write or set presented in the same cycle as rst.

Configuration
REQ-027 SHALL, when FP_RF_BYPASS_EN is defined, return frd_data[w] on frs_data[p] when frd_en[w]=1 and frd_addr[w]=frs_addr[p] in the same cycle, using the highest matching w, and force frs_busy[p]=0 unless a same-cycle set targets that address.
REQ-028 SHALL, when FP_RF_BYPASS_EN is undefined, return only stored values; the write becomes visible on the next cycle.

Structure
REQ-029 SHALL place the default XLEN, NREGS, NRD and NWR constants and the fp_rf_addr_t typedef in package fp_rf_pkg.
REQ-030 SHALL implement the busy-bit logic of REQ-019 to REQ-023 in sub-module fp_rf_scoreboard; data storage and bypass logic stay in the top module.

Verification
REQ-031 SHALL test reset: write f5=32'h3F800000, then pulse rst -> next cycle f5 reads 0 and busy=0.
REQ-032 SHALL test a dual-write conflict: ports 0 and 1 both write f7, with 32'h11111111 and 32'h22222222 -> next cycle f7 reads 32'h22222222.
REQ-033 SHALL test the scoreboard: set f3, then 4 cycles of busy=1, then write f3 -> busy=0 on the next cycle; a same-cycle set and write of f3 -> busy stays 1.
REQ-034 SHALL test flush: set f1, f2 and f31, then flush -> all busy=0 next cycle and data is unchanged.
REQ-035 SHALL test bypass: write f9=32'hDEADBEEF and read f9 in the same cycle -> with the macro, 32'hDEADBEEF; without it, the old value.
REQ-036 SHALL test parameters: NREGS=16, NRD=2 and NWR=1 elaborate, and a write/read of f15 round-trips.
